// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns PC, IR and the carry
// flag, and gates the registered decoder's control word onto the datapath loads.
module cpu_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [7:0] ROM_DATA,
  input  logic [5:0] DECODED,
  input  logic       ALU_CARRY,
  output logic [3:0] PC,
  output logic [3:0] ORDER,
  output logic [3:0] IMM,
  output logic [1:0] SEL,
  output logic [3:0] LOAD_N,
  output logic       C_FLAG,
  output logic       BUSY,
  output logic       INSTR_DONE,
  output logic       ILLEGAL
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] pc_r, pc_s;
  logic [7:0] ir_r, ir_s;
  logic       c_flag_r, c_flag_s;
  logic [3:0] op_s;
  logic       defined_s, taken_s, exec_s;

  // Opcodes 8, A, C and D decode to all-zero (every load active) and must be masked.
  function automatic logic op_defined(input logic [3:0] op);
    case (op)
      4'h8, 4'hA, 4'hC, 4'hD: op_defined = 1'b0;
      default:                op_defined = 1'b1;
    endcase
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic c);
    case (op)
      4'hF:    jump_taken = 1'b1;
      4'hE:    jump_taken = ~c;
      default: jump_taken = 1'b0;
    endcase
  endfunction

  assign op_s      = ir_r[7:4];
  assign defined_s = op_defined(op_s);
  assign taken_s   = jump_taken(op_s, c_flag_r);
  assign exec_s    = (state_r == EXEC);

  // Next-state logic; halting only happens at the EXEC -> IDLE boundary.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (RUN || STEP) state_s = FETCH;
        else             state_s = IDLE;
      end
      FETCH:  state_s = DECODE;
      DECODE: state_s = EXEC;
      EXEC: begin
        if (RUN) state_s = FETCH;
        else     state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Architectural updates: IR at the end of FETCH, PC and carry at the end of EXEC.
  always_comb begin
    pc_s     = pc_r;
    ir_s     = ir_r;
    c_flag_s = c_flag_r;
    if (state_r == FETCH) begin
      ir_s = ROM_DATA;
    end else if (exec_s) begin
      pc_s = taken_s ? ir_r[3:0] : pc_r + 4'd1;
      if (op_s == 4'hE || op_s == 4'hF)
        c_flag_s = 1'b0;
      else if (defined_s && op_s <= 4'hB)
        c_flag_s = ALU_CARRY;
      else
        c_flag_s = c_flag_r;
    end else begin
      pc_s = pc_r;
    end
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      pc_r     <= 4'd0;
      ir_r     <= 8'h00;
      c_flag_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      ir_r     <= ir_s;
      c_flag_r <= c_flag_s;
    end
  end

  // Datapath controls; reset gates them off combinationally so an EXEC in the reset cycle commits nothing.
  always_comb begin
    SEL        = 2'b00;
    LOAD_N     = 4'b1111;
    INSTR_DONE = 1'b0;
    ILLEGAL    = 1'b0;
    if (exec_s && !RST) begin
      SEL        = DECODED[5:4];
      LOAD_N     = {(defined_s ? DECODED[3:1] : 3'b111), ~taken_s};
      INSTR_DONE = 1'b1;
      ILLEGAL    = ~defined_s;
    end else begin
      SEL        = 2'b00;
      LOAD_N     = 4'b1111;
    end
  end

  assign PC     = pc_r;
  assign ORDER  = ir_r[7:4];
  assign IMM    = ir_r[3:0];
  assign C_FLAG = c_flag_r;
  assign BUSY   = (state_r != IDLE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model of the 4-bit
// ISA predicts each completed instruction; a negedge monitor checks the DUT.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, step, alu_carry;
  logic [7:0] rom_data;
  logic [5:0] decoded = 6'b000000;
  logic [3:0] pc, order, imm, load_n;
  logic [1:0] sel;
  logic       c_flag, busy, instr_done, illegal;

  logic [7:0]  rom [16];
  logic [15:0] carry_tab;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [3:0] pc;
    logic [1:0] sel;
    logic [3:0] load_n;
    logic       ill;
    logic [3:0] pc_nx;
    logic       c_nx;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_e;
  bit   pend = 0;

  cpu_sequencer dut (
    .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .ROM_DATA(rom_data),
    .DECODED(decoded), .ALU_CARRY(alu_carry), .PC(pc), .ORDER(order),
    .IMM(imm), .SEL(sel), .LOAD_N(load_n), .C_FLAG(c_flag), .BUSY(busy),
    .INSTR_DONE(instr_done), .ILLEGAL(illegal)
  );

  always #5 clk = ~clk;

  assign rom_data  = rom[pc];
  assign alu_carry = carry_tab[pc];

  // Environment decoder: {sel[1:0], loadA_n, loadB_n, loadOUT_n, loadPC_n}, one cycle latency.
  function automatic logic [5:0] dec_word(input logic [3:0] op);
    case (op)
      4'h0: dec_word = 6'b000111;
      4'h1: dec_word = 6'b010111;
      4'h2: dec_word = 6'b100111;
      4'h3: dec_word = 6'b110111;
      4'h4: dec_word = 6'b001011;
      4'h5: dec_word = 6'b011011;
      4'h6: dec_word = 6'b101011;
      4'h7: dec_word = 6'b111011;
      4'h9: dec_word = 6'b011101;
      4'hB: dec_word = 6'b111101;
      4'hE: dec_word = 6'b111110;
      4'hF: dec_word = 6'b111110;
      default: dec_word = 6'b000000;
    endcase
  endfunction

  always @(posedge clk) decoded <= dec_word(order);

  // Reference: operand source by instruction class (A, B, IN port, immediate).
  function automatic logic [1:0] sel_ref(input logic [3:0] op);
    case (op)
      4'h0, 4'h4:                   sel_ref = 2'b00;
      4'h1, 4'h5, 4'h9:             sel_ref = 2'b01;
      4'h2, 4'h6:                   sel_ref = 2'b10;
      4'h3, 4'h7, 4'hB, 4'hE, 4'hF: sel_ref = 2'b11;
      default:                      sel_ref = 2'b00;
    endcase
  endfunction

  // Reference: destination register by instruction class; jumps by flag.
  function automatic logic [3:0] load_ref(input logic [3:0] op, input logic c);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: load_ref = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'h7: load_ref = 4'b1011;
      4'h9, 4'hB:             load_ref = 4'b1101;
      4'hE:                   load_ref = c ? 4'b1111 : 4'b1110;
      4'hF:                   load_ref = 4'b1110;
      default:                load_ref = 4'b1111;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Run the program from reset for n instructions and queue the expected results.
  task automatic push_model(input int n);
    logic [3:0] p, op, im;
    logic       c, def, tk;
    exp_t       e;
    p = 4'd0;
    c = 1'b0;
    for (int k = 0; k < n; k++) begin
      op  = rom[p][7:4];
      im  = rom[p][3:0];
      def = !(op == 4'h8 || op == 4'hA || op == 4'hC || op == 4'hD);
      tk  = (op == 4'hF) || (op == 4'hE && !c);
      e.pc     = p;
      e.sel    = sel_ref(op);
      e.load_n = load_ref(op, c);
      e.ill    = !def;
      e.pc_nx  = tk ? im : p + 4'd1;
      if (op >= 4'hE)              e.c_nx = 1'b0;
      else if (def && op <= 4'hB)  e.c_nx = carry_tab[p];
      else                         e.c_nx = c;
      exp_q.push_back(e);
      p = e.pc_nx;
      c = e.c_nx;
    end
  endtask

  // Monitor: compares each completed instruction and the state it leaves behind.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      check("load_n_in_reset", 32'(load_n), 32'hF);
    end else begin
      if (pend) begin
        check("pc_after_exec", 32'(pc), 32'(pend_e.pc_nx));
        check("c_flag_after_exec", 32'(c_flag), 32'(pend_e.c_nx));
        pend = 0;
      end
      if (instr_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: instr_done=1 at pc=%0h, expected no instruction", pc);
        end else begin
          pend_e = exp_q.pop_front();
          pend   = 1;
          check("exec_pc", 32'(pc), 32'(pend_e.pc));
          check("exec_sel", 32'(sel), 32'(pend_e.sel));
          check("exec_load_n", 32'(load_n), 32'(pend_e.load_n));
          check("exec_illegal", 32'(illegal), 32'(pend_e.ill));
        end
      end else begin
        check("idle_load_n", 32'(load_n), 32'hF);
        check("idle_sel", 32'(sel), 32'h0);
        check("idle_illegal", 32'(illegal), 32'h0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    carry_tab = 16'h0000;
  endtask

  // mode 0: RUN held high (also checks 3-cycle issue rate); mode 1: random RUN/STEP.
  task automatic run_program(input int n, input int mode);
    int done = 0, cycles = 0, since = 0;
    do_reset();
    push_model(n);
    if (mode == 0) begin run = 1'b1; step = 1'b0; end
    else begin run = ($urandom_range(3) != 0); step = $urandom_range(1); end
    while (done < n && cycles < 60 * n) begin
      @(posedge clk); #1;
      cycles++;
      since++;
      if (instr_done === 1'b1) begin
        done++;
        if (mode == 0) check("issue_interval", 32'(since), 32'd3);
        since = 0;
      end
      if (done >= n) begin
        run = 1'b0; step = 1'b0;
      end else if (mode == 1) begin
        run = ($urandom_range(3) != 0); step = $urandom_range(1);
      end
    end
    check("instr_count", 32'(done), 32'(n));
    repeat (3) @(posedge clk);
    #1;
    check("halted_idle", 32'(busy), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic step_test();
    int busy_cnt = 0, done_cnt = 0;
    clear_rom();
    rom[0] = 8'h5A;
    do_reset();
    push_model(1);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      busy_cnt += int'(busy);
      done_cnt += int'(instr_done);
      if (i == 1) step = 1'b1;
      if (i == 2) step = 1'b0;
    end
    check("step_busy_cycles", 32'(busy_cnt), 32'd3);
    check("step_done_pulses", 32'(done_cnt), 32'd1);
    check("step_pc", 32'(pc), 32'd1);
    check("step_queue", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic reset_in_exec_test();
    clear_rom();
    rom[0] = 8'h03;
    rom[1] = 8'h90;
    carry_tab = 16'h0001;
    do_reset();
    push_model(1);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (instr_done === 1'b1) break;
    end
    check("first_exec_seen", 32'(instr_done), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("second_exec_reached", 32'(instr_done), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_exec_load_n", 32'(load_n), 32'hF);
    check("rst_exec_done", 32'(instr_done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_pc", 32'(pc), 32'h0);
    check("post_rst_c_flag", 32'(c_flag), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_c_flag", 32'(c_flag), 32'h0);
    check("rst_order", 32'(order), 32'h0);
    check("rst_imm", 32'(imm), 32'h0);
    check("rst_done", 32'(instr_done), 32'h0);

    clear_rom(); rom[0] = 8'h03;
    run_program(1, 0);

    clear_rom(); rom[0] = 8'h0F; rom[1] = 8'hE5; carry_tab = 16'h0001;
    run_program(2, 0);
    clear_rom(); rom[0] = 8'h0F; rom[1] = 8'hE5;
    run_program(2, 0);

    clear_rom(); rom[0] = 8'hFF; rom[15] = 8'h30; carry_tab = 16'h8000;
    run_program(3, 0);
    clear_rom(); rom[0] = 8'hFF; rom[15] = 8'hF7; carry_tab = 16'h8000;
    run_program(2, 0);

    clear_rom(); rom[0] = 8'h03; rom[1] = 8'h03; rom[2] = 8'hA9; carry_tab = 16'h0003;
    run_program(4, 0);

    step_test();
    reset_in_exec_test();

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      carry_tab = 16'($urandom);
      run_program(25, (p == 0) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
